antares_mem_arbiter: RTL and testbench

- Shares one single-port memory/bus slave between the Antares core instruction port (iport) and data port (dport).
- Sits between antares_core and a single-port memory, replacing the dual-port memory arrangement.
- Two-master, one-slave arbiter with round-robin tie-break and a per-transaction watchdog timeout.
- All handshakes are enable/ready: a master holds enable until it sees ready or error.

---
 rtl/antares_mem_arbiter_pkg.sv | 26 ++
 rtl/antares_bus_watchdog.sv | 37 +++
 rtl/antares_mem_arbiter.sv | 113 +++++++++++
 tb/tb_antares_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/antares_mem_arbiter_pkg.sv
// Shared state encodings, grant identifiers and the arbitration pick rule
// for the Antares instruction/data memory arbiter.
package antares_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

    // On a tie the master that was not served last wins.
    function automatic arb_state_e arb_pick(input logic ien, input logic den, input logic last);
        if (ien && den) begin
            return (last == ARB_D) ? ARB_GNT_I : ARB_GNT_D;
        end else if (ien) begin
            return ARB_GNT_I;
        end else if (den) begin
            return ARB_GNT_D;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/antares_bus_watchdog.sv
// Per-transaction watchdog: counts active cycles and flags the cycle in which
// the transaction has run out of time.
module antares_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // First active cycle sees count 0, so the last allowed cycle sees TIMEOUT-1.
    assign expired = run && (count_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/antares_mem_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter with round-robin
// tie-break and a watchdog that aborts stalled transactions with an error.
module antares_mem_arbiter
    import antares_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iport_address,
    input  logic [3:0]  iport_wr,
    input  logic        iport_enable,
    output logic [31:0] iport_data_i,
    output logic        iport_ready,
    output logic        iport_error,
    input  logic [31:0] dport_address,
    input  logic [31:0] dport_data_o,
    input  logic [3:0]  dport_wr,
    input  logic        dport_enable,
    output logic [31:0] dport_data_i,
    output logic        dport_ready,
    output logic        dport_error,
    output logic [31:0] m_address,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_wr,
    output logic        m_enable,
    input  logic [31:0] m_data_i,
    input  logic        m_ready,
    input  logic        m_error
);

    arb_state_e state_q;
    logic       last_grant_q;

    logic gnt_i;
    logic gnt_d;
    logic active;
    logic expired;
    logic rsp_ready;
    logic rsp_error;
    logic done;
    logic wd_clear;

    assign gnt_i  = (state_q == ARB_GNT_I);
    assign gnt_d  = (state_q == ARB_GNT_D);
    // A granted master that has dropped enable no longer owns the bus.
    assign active = (gnt_i && iport_enable) || (gnt_d && dport_enable);

    // Error wins over ready; a timeout only fires when the slave is silent.
    assign rsp_error = active && (m_error || (expired && !m_ready));
    assign rsp_ready = active && m_ready && !m_error;
    assign done      = rsp_error || rsp_ready;
    assign wd_clear  = !active || done;

    antares_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (active),
        .clear  (wd_clear),
        .expired(expired)
    );

    always_comb begin
        m_enable  = active;
        m_address = 32'h0;
        m_wr      = 4'h0;
        m_data_o  = 32'h0;
        if (active && gnt_i) begin
            m_address = iport_address;
            m_wr      = iport_wr;
        end else if (active && gnt_d) begin
            m_address = dport_address;
            m_wr      = dport_wr;
            m_data_o  = dport_data_o;
        end
    end

    assign iport_data_i = m_data_i;
    assign dport_data_i = m_data_i;

    // Responses are suppressed while reset is asserted so an aborted
    // transaction never reports back to its master.
    assign iport_ready = rst && gnt_i && rsp_ready;
    assign iport_error = rst && gnt_i && rsp_error;
    assign dport_ready = rst && gnt_d && rsp_ready;
    assign dport_error = rst && gnt_d && rsp_error;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_D;
        end else begin
            case (state_q)
                ARB_GNT_I, ARB_GNT_D: begin
                    if (!active) begin
                        state_q <= ARB_IDLE;
                    end else if (done) begin
                        last_grant_q <= gnt_d ? ARB_D : ARB_I;
                        state_q      <= arb_pick(iport_enable, dport_enable, gnt_d ? ARB_D : ARB_I);
                    end
                end
                default: begin
                    state_q <= arb_pick(iport_enable, dport_enable, last_grant_q);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_antares_mem_arbiter.sv
// Directed testbench for antares_mem_arbiter with hand-computed expectations.
module tb_antares_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iport_address;
    logic [3:0]  iport_wr;
    logic        iport_enable;
    logic [31:0] iport_data_i;
    logic        iport_ready;
    logic        iport_error;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_i;
    logic        dport_ready;
    logic        dport_error;
    logic [31:0] m_address;
    logic [31:0] m_data_o;
    logic [3:0]  m_wr;
    logic        m_enable;
    logic [31:0] m_data_i;
    logic        m_ready;
    logic        m_error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    antares_mem_arbiter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .iport_address(iport_address),
        .iport_wr     (iport_wr),
        .iport_enable (iport_enable),
        .iport_data_i (iport_data_i),
        .iport_ready  (iport_ready),
        .iport_error  (iport_error),
        .dport_address(dport_address),
        .dport_data_o (dport_data_o),
        .dport_wr     (dport_wr),
        .dport_enable (dport_enable),
        .dport_data_i (dport_data_i),
        .dport_ready  (dport_ready),
        .dport_error  (dport_error),
        .m_address    (m_address),
        .m_data_o     (m_data_o),
        .m_wr         (m_wr),
        .m_enable     (m_enable),
        .m_data_i     (m_data_i),
        .m_ready      (m_ready),
        .m_error      (m_error)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        iport_address = 32'h0; iport_wr = 4'h0; iport_enable = 1'b0;
        dport_address = 32'h0; dport_data_o = 32'h0; dport_wr = 4'h0; dport_enable = 1'b0;
        m_data_i = 32'h0; m_ready = 1'b0; m_error = 1'b0;

        // Reset state
        tick(); tick(); settle();
        chk("rst_m_enable", m_enable, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_iready", iport_ready, 0);
        chk("rst_derror", dport_error, 0);
        rst = 1'b1;

        // Single iport read, slave answers on the 3rd granted cycle
        tick();
        iport_address = 32'h100; iport_enable = 1'b1;
        settle();
        chk("t1_idle_m_enable", m_enable, 0);
        tick(); settle();
        chk("t1_m_enable", m_enable, 1);
        chk("t1_m_address", m_address, 32'h100);
        chk("t1_m_data_o", m_data_o, 32'h0);
        chk("t1_iready_early", iport_ready, 0);
        tick(); tick();
        m_ready = 1'b1; m_data_i = 32'h12345678;
        settle();
        chk("t1_iready", iport_ready, 1);
        chk("t1_idata", iport_data_i, 32'h12345678);
        chk("t1_ddata", dport_data_i, 32'h12345678);
        chk("t1_dready", dport_ready, 0);
        chk("t1_derror", dport_error, 0);
        tick();
        m_ready = 1'b0; iport_enable = 1'b0;
        settle();
        chk("t1_iready_once", iport_ready, 0);
        chk("t1_m_enable_off", m_enable, 0);
        tick(); tick();

        // Both masters from reset: grants alternate I,D,I,D,I,D
        rst = 1'b0;
        tick();
        rst = 1'b1;
        iport_address = 32'h100; iport_enable = 1'b1;
        dport_address = 32'h200; dport_enable = 1'b1;
        tick();
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t2_addr", m_address, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("t2_iready", iport_ready, (k % 2 == 0) ? 1 : 0);
            chk("t2_dready", dport_ready, (k % 2 == 0) ? 0 : 1);
            tick();
        end
        m_ready = 1'b0; iport_enable = 1'b0; dport_enable = 1'b0;
        tick(); tick();

        // dport write
        dport_address = 32'h200; dport_data_o = 32'hDEADBEEF; dport_wr = 4'hF; dport_enable = 1'b1;
        settle();
        chk("t3_idle_m_wr", m_wr, 0);
        chk("t3_idle_m_data_o", m_data_o, 0);
        tick(); settle();
        chk("t3_m_data_o", m_data_o, 32'hDEADBEEF);
        chk("t3_m_wr", m_wr, 4'hF);
        chk("t3_m_address", m_address, 32'h200);
        m_ready = 1'b1;
        settle();
        chk("t3_dready", dport_ready, 1);
        chk("t3_iready", iport_ready, 0);
        tick();
        dport_enable = 1'b0; m_ready = 1'b0;
        settle();
        chk("t3_drop_m_wr", m_wr, 0);
        chk("t3_drop_m_enable", m_enable, 0);
        tick(); settle();
        chk("t3_idle_after_m_wr", m_wr, 0);
        dport_wr = 4'h0; dport_data_o = 32'h0;

        // Watchdog timeout with a pending iport request
        dport_address = 32'h204; dport_enable = 1'b1;
        tick();
        iport_address = 32'h300; iport_enable = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            settle();
            chk("t4_derror", dport_error, (n == 16) ? 1 : 0);
            chk("t4_m_address", m_address, 32'h204);
            if (n < 16) tick();
        end
        tick();
        dport_enable = 1'b0;
        settle();
        chk("t4_derror_once", dport_error, 0);
        chk("t4_next_m_address", m_address, 32'h300);
        chk("t4_next_m_enable", m_enable, 1);
        m_ready = 1'b1; m_data_i = 32'hA5A5A5A5;
        settle();
        chk("t4_iready", iport_ready, 1);
        tick();
        iport_enable = 1'b0; m_ready = 1'b0;
        tick();

        // Simultaneous ready and error, then a normal transaction
        iport_address = 32'h104; iport_enable = 1'b1;
        tick();
        m_ready = 1'b1; m_error = 1'b1;
        settle();
        chk("t5_ierror", iport_error, 1);
        chk("t5_iready", iport_ready, 0);
        tick();
        m_error = 1'b0; m_data_i = 32'hCAFEF00D;
        settle();
        chk("t5_next_iready", iport_ready, 1);
        chk("t5_next_ierror", iport_error, 0);
        chk("t5_next_idata", iport_data_i, 32'hCAFEF00D);
        tick();
        m_ready = 1'b0; iport_enable = 1'b0;
        tick();

        // Reset three cycles into a dport grant
        dport_address = 32'h208; dport_enable = 1'b1;
        tick(); tick(); tick();
        settle();
        chk("t6_m_enable_pre", m_enable, 1);
        rst = 1'b0; iport_address = 32'h108; iport_enable = 1'b1;
        settle();
        chk("t6_rst_dready", dport_ready, 0);
        chk("t6_rst_derror", dport_error, 0);
        tick(); settle();
        chk("t6_m_enable_rst", m_enable, 0);
        chk("t6_derror_rst", dport_error, 0);
        chk("t6_iready_rst", iport_ready, 0);
        rst = 1'b1;
        tick(); settle();
        chk("t6_regrant_m_enable", m_enable, 1);
        chk("t6_regrant_addr", m_address, 32'h108);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
